// File: rtl/aibnd_dcc_ctrl_if.sv
// Signal bundle between the DCC loop controller (master) and its counter/detector side (slave).
// Optional AIBND_DCC_SHADOW_CHK_EN adds the shadow_mismatch status line.
// Handshake: dcc_en is a level request; dcc_done qualifies dcc_code/dcc_err and holds until dcc_en drops.
interface aibnd_dcc_ctrl_if;
  logic       dcc_en;
  logic       pd_out;
  logic [4:0] cnt_q;
  logic       cnt_full;
  logic       cnt_dir;
  logic       cnt_hold;
  logic       cnt_nrst;
  logic [4:0] dcc_code;
  logic       dcc_done;
  logic       dcc_err;
`ifdef AIBND_DCC_SHADOW_CHK_EN
  logic       shadow_mismatch;
`endif

  modport master (
`ifdef AIBND_DCC_SHADOW_CHK_EN
    output shadow_mismatch,
`endif
    input  dcc_en, pd_out, cnt_q, cnt_full,
    output cnt_dir, cnt_hold, cnt_nrst, dcc_code, dcc_done, dcc_err
  );

  modport slave (
`ifdef AIBND_DCC_SHADOW_CHK_EN
    input  shadow_mismatch,
`endif
    output dcc_en, pd_out, cnt_q, cnt_full,
    input  cnt_dir, cnt_hold, cnt_nrst, dcc_code, dcc_done, dcc_err
  );
endinterface

// File: rtl/aibnd_dcc_ctrl_fsm.sv
// DCC loop controller: settle, majority-sample the duty detector, step the 5-bit counter until lock.
// Optional AIBND_DCC_SHADOW_CHK_EN cross-checks cnt_q against an internal shadow count.
module aibnd_dcc_ctrl_fsm #(
  parameter int SETTLE_CYC = 8,
  parameter int AVG_LOG2   = 2
) (
  input logic             clk,
  input logic             rst,
  aibnd_dcc_ctrl_if.master bus
);
  localparam int         NSAMP       = 1 << AVG_LOG2;
  localparam logic [4:0] HALF        = 5'(NSAMP >> 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] SAMP_LAST   = 8'(NSAMP - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, STEP, LOCKED, SAT} state_t;

  state_t     state;
  logic [7:0] cyc;
  logic [4:0] ones;
  logic       dir_p, hold_p;
  logic       nrst_q;
  logic [4:0] code_q;
  logic       done_q, err_q;
  logic       dir_n, hold_n;
  logic [4:0] ones_nxt;
  logic       inc, full;

  assign ones_nxt = ones + {4'd0, bus.pd_out};
  // With a single sample HALF is 0, so inc reduces to that sample.
  assign inc      = ones_nxt > HALF;

`ifdef AIBND_DCC_SHADOW_CHK_EN
  logic [4:0] shadow;
  logic       mismatch_q;
  assign full                = bus.cnt_full | (bus.cnt_q == 5'd31);
  assign bus.shadow_mismatch = mismatch_q;
`else
  assign full                = bus.cnt_full;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cyc    <= '0;
      ones   <= '0;
      dir_p  <= 1'b0;
      hold_p <= 1'b1;
      nrst_q <= 1'b0;
      code_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef AIBND_DCC_SHADOW_CHK_EN
      shadow     <= '0;
      mismatch_q <= 1'b0;
`endif
    end else if (!bus.dcc_en) begin
      state  <= IDLE;
      cyc    <= '0;
      ones   <= '0;
      dir_p  <= 1'b0;
      hold_p <= 1'b1;
      nrst_q <= 1'b0;
      code_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef AIBND_DCC_SHADOW_CHK_EN
      shadow     <= '0;
      mismatch_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state  <= SETTLE;
          cyc    <= '0;
          nrst_q <= 1'b1;
          hold_p <= 1'b1;
        end
        SETTLE: begin
          if (cyc == SETTLE_LAST) begin
            cyc  <= '0;
            ones <= '0;
`ifdef AIBND_DCC_SHADOW_CHK_EN
            if (bus.cnt_q != shadow) begin
              state      <= SAT;
              code_q     <= bus.cnt_q;
              done_q     <= 1'b1;
              err_q      <= 1'b1;
              mismatch_q <= 1'b1;
            end else begin
              state <= SAMPLE;
            end
`else
            state <= SAMPLE;
`endif
          end else begin
            cyc <= cyc + 8'd1;
          end
        end
        SAMPLE: begin
          if (cyc == SAMP_LAST) begin
            cyc  <= '0;
            ones <= '0;
            if (!inc) begin
              state  <= LOCKED;
              code_q <= bus.cnt_q;
              done_q <= 1'b1;
            end else if (full) begin
              state  <= SAT;
              code_q <= bus.cnt_q;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              state  <= STEP;
              dir_p  <= 1'b1;
              hold_p <= 1'b0;
`ifdef AIBND_DCC_SHADOW_CHK_EN
              shadow <= shadow + 5'd1;
`endif
            end
          end else begin
            cyc  <= cyc + 8'd1;
            ones <= ones_nxt;
          end
        end
        STEP: begin
          state  <= SETTLE;
          cyc    <= '0;
          dir_p  <= 1'b0;
          hold_p <= 1'b1;
        end
        LOCKED, SAT: begin
          state <= state;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The counter gates clk with dir: retime on the falling edge so dir is stable across the high phase.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      dir_n  <= 1'b0;
      hold_n <= 1'b1;
    end else begin
      dir_n  <= dir_p;
      hold_n <= hold_p;
    end
  end

  assign bus.cnt_dir  = dir_n;
  assign bus.cnt_hold = hold_n;
  assign bus.cnt_nrst = nrst_q;
  assign bus.dcc_code = code_q;
  assign bus.dcc_done = done_q;
  assign bus.dcc_err  = err_q;
endmodule

// File: tb/tb_aibnd_dcc_ctrl_fsm.sv
// Bench for aibnd_dcc_ctrl_fsm with a behavioural 5-bit counter and a scripted duty detector.
// Define AIBND_DCC_SHADOW_CHK_EN to also exercise the shadow-count mismatch path.
`timescale 1ns/1ps
module tb_aibnd_dcc_ctrl_fsm;
  localparam int SETTLE = 8;
  localparam int NSAMP  = 4;
  localparam int W      = 12;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic bench_live = 1'b0;
  always #5 clk = ~clk;

  aibnd_dcc_ctrl_if bus();
  aibnd_dcc_ctrl_fsm #(.SETTLE_CYC(SETTLE), .AVG_LOG2(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  // behavioural counter; skip_en drops one increment at code 5
  logic [4:0] q;
  logic       skipped;
  logic       skip_en;
  always @(posedge clk or negedge bus.cnt_nrst) begin
    if (!bus.cnt_nrst) begin
      q       <= 5'd0;
      skipped <= 1'b0;
    end else if (bus.cnt_dir && !bus.cnt_hold) begin
      if (skip_en && !skipped && q == 5'd5) skipped <= 1'b1;
      else q <= q + 5'd1;
    end
  end
  assign bus.cnt_q    = q;
  assign bus.cnt_full = (q == 5'd31);

  // detector: mode 0 -> 1 while code < thr; mode 1 -> pattern over the first window only
  int         cyc = 0;
  int         en_cyc = 0;
  int         pd_mode;
  int         thr;
  logic [3:0] pat;
  int         rel;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    rel = cyc - en_cyc;
    if (pd_mode == 0) bus.pd_out = (int'(q) < thr);
    else if (rel >= SETTLE + 1 && rel <= SETTLE + NSAMP) bus.pd_out = pat[SETTLE + NSAMP - rel];
    else bus.pd_out = 1'b0;
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic logic [W-1:0] mk_exp(input logic err, input logic [4:0] code, input int pulses);
    return {err, code, 6'(pulses)};
  endfunction

  // monitor: counts dir pulses, checks width and first-step latency, pops on dcc_done rise
  int           pulse_cnt = 0;
  int           dir_run   = 0;
  logic         done_prev = 1'b0;
  logic         en_prev   = 1'b0;
  logic         dir_prev  = 1'b0;
  logic [W-1:0] exp_item;
  always @(posedge clk) begin
    #1;
    if (bench_live && !rst) begin
      if (bus.dcc_en && !en_prev) pulse_cnt = 0;
      if (bus.cnt_dir) begin
        if (!dir_prev) begin
          // monitor runs one posedge after the pulse launches, hence the -1
          if (pulse_cnt == 0) check("first_step_latency", cyc - en_cyc - 1, 1 + SETTLE + NSAMP);
          pulse_cnt++;
        end
        dir_run++;
      end else begin
        if (dir_prev) check("dir_width", dir_run, 1);
        dir_run = 0;
      end
      if (bus.dcc_done && !done_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_item = exp_q.pop_front();
          check("done_err", int'(bus.dcc_err), int'(exp_item[11]));
          check("done_code", int'(bus.dcc_code), int'(exp_item[10:6]));
          check("done_pulses", pulse_cnt, int'(exp_item[5:0]));
        end
      end
    end else begin
      dir_run = 0;
    end
    done_prev = bus.dcc_done;
    en_prev   = bus.dcc_en;
    dir_prev  = bus.cnt_dir;
  end

  always @(bus.cnt_dir) begin
    if (bench_live && !rst) check("dir_negedge_aligned", int'(clk), 0);
  end

  // driver tasks
  task automatic enable();
    @(negedge clk);
    en_cyc     = cyc;
    bus.dcc_en = 1'b1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!bus.dcc_done && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!bus.dcc_done) begin
      check({name, "_timeout"}, 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic stop_and_check(input string name);
    @(negedge clk);
    bus.dcc_en = 1'b0;
    @(negedge clk);
    #1;
    check({name, "_idle_nrst"}, int'(bus.cnt_nrst), 0);
    check({name, "_idle_done"}, int'(bus.dcc_done), 0);
    check({name, "_idle_code"}, int'(bus.dcc_code), 0);
    check({name, "_idle_dir"},  int'(bus.cnt_dir), 0);
`ifdef AIBND_DCC_SHADOW_CHK_EN
    check({name, "_idle_shadow"}, int'(bus.shadow_mismatch), 0);
`endif
  endtask

  task automatic run(input string name, input int mode, input int t, input logic [3:0] p,
                     input logic [W-1:0] exp);
    pd_mode = mode;
    thr     = t;
    pat     = p;
    exp_q.push_back(exp);
    enable();
    wait_done(name, 900);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int k;
    bus.dcc_en = 1'b0;
    pd_mode    = 0;
    thr        = 0;
    pat        = 4'b0000;
    skip_en    = 1'b0;
    rst        = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dir",  int'(bus.cnt_dir), 0);
    check("rst_hold", int'(bus.cnt_hold), 1);
    check("rst_nrst", int'(bus.cnt_nrst), 0);
    check("rst_code", int'(bus.dcc_code), 0);
    check("rst_done", int'(bus.dcc_done), 0);
    check("rst_err",  int'(bus.dcc_err), 0);
    rst = 1'b0;
    bench_live = 1'b1;
    repeat (2) @(negedge clk);

    // lock at 13
    run("lock13", 0, 13, 4'b0000, mk_exp(1'b0, 5'd13, 13));
    check("lock13_hold", int'(bus.cnt_hold), 1);
    stop_and_check("lock13");

    // stuck high: saturate at 31 with no further pulse
    run("sat", 0, 32, 4'b0000, mk_exp(1'b1, 5'd31, 31));
    repeat (40) @(negedge clk);
    check("sat_no_32nd_pulse", pulse_cnt, 31);
    check("sat_counter_code", int'(q), 31);
    stop_and_check("sat");

    // majority: tie does not step, 3-of-4 does
    run("tie", 1, 0, 4'b1100, mk_exp(1'b0, 5'd0, 0));
    stop_and_check("tie");
    run("maj", 1, 0, 4'b1110, mk_exp(1'b0, 5'd1, 1));
    stop_and_check("maj");

    // drop enable during SETTLE at code 7, then restart from 0
    pd_mode = 0;
    thr     = 20;
    enable();
    k = 0;
    while (q != 5'd7 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (q != 5'd7) check("drop_reach7_timeout", int'(q), 7);
    repeat (3) @(negedge clk);
    stop_and_check("drop");
    check("drop_counter_cleared", int'(q), 0);
    run("restart", 0, 3, 4'b0000, mk_exp(1'b0, 5'd3, 3));
    stop_and_check("restart");

`ifdef AIBND_DCC_SHADOW_CHK_EN
    skip_en = 1'b1;
    run("shadow", 0, 10, 4'b0000, mk_exp(1'b1, 5'd5, 6));
    check("shadow_mismatch", int'(bus.shadow_mismatch), 1);
    stop_and_check("shadow");
    skip_en = 1'b0;
`endif

    // async reset in the middle of a step pulse
    pd_mode = 0;
    thr     = 20;
    enable();
    k = 0;
    while (!bus.cnt_dir && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!bus.cnt_dir) check("rstmid_pulse_timeout", 0, 1);
    #1;
    rst = 1'b1;
    #1;
    check("rstmid_dir",  int'(bus.cnt_dir), 0);
    check("rstmid_nrst", int'(bus.cnt_nrst), 0);
    check("rstmid_hold", int'(bus.cnt_hold), 1);
    check("rstmid_done", int'(bus.dcc_done), 0);
    bus.dcc_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid_idle_nrst", int'(bus.cnt_nrst), 0);
    check("rstmid_idle_hold", int'(bus.cnt_hold), 1);
    run("post_rst", 0, 2, 4'b0000, mk_exp(1'b0, 5'd2, 2));
    stop_and_check("post_rst");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/aibnd_dcc_ctrl_fsm.md
Name: aibnd_dcc_ctrl_fsm

Overview:
Loop controller for the DCC 5-bit up-counter. It drives the counter's count-enable (dir), hold and active-low reset, and reads back its code and full flag. It settles, majority-samples the duty-cycle detector, and steps the counter one code at a time until the detector stops requesting increase, then freezes the code and flags done. It sits beside the counter in the aibnd DCC slice.

Parameters:
SETTLE_CYC, 8, clk cycles waited after counter release or each step before sampling (legal 2..255)
AVG_LOG2, 2, detector sampled 2**AVG_LOG2 cycles per decision (legal 0..4)

Ports:
clk  input  1  controller clock; same clock feeds the counter's clk pin
rst  input  1  asynchronous, active-high reset
dcc_en  input  1  level enable; 0 aborts and returns to IDLE
pd_out  input  1  duty detector; 1 = duty low, request code increase
cnt_q  input  5  counter code, {q4..q0}
cnt_full  input  1  counter full flag (code == 31)
cnt_dir  output  1  counter dir/count-enable; one-cycle pulse = one increment
cnt_hold  output  1  counter hold_state
cnt_nrst  output  1  counter nrst, active-low
dcc_code  output  5  code captured at lock/saturation
dcc_done  output  1  search finished (LOCKED or SAT)
dcc_err  output  1  saturated at 31 with increase still requested (or shadow mismatch, see option)

Behaviour:
- Reset (async, rst=1): state IDLE; cnt_dir=0, cnt_hold=1, cnt_nrst=0, dcc_code=0, dcc_done=0, dcc_err=0; all counters 0.
- Counter gates clk with dir, so cnt_dir and cnt_hold are retimed on the falling edge of clk. This keeps them stable for the whole high phase, so the counter sees exactly one clean rising edge per pulse. All other state is posedge. Reset clears the negedge flops too.
- States: IDLE, SETTLE, SAMPLE, STEP, LOCKED, SAT.
- IDLE: cnt_nrst=0, cnt_hold=1. With dcc_en=1, go to SETTLE next cycle; cnt_nrst=1 from that cycle.
- SETTLE: cnt_hold=1. Wait SETTLE_CYC cycles (cycles 0..SETTLE_CYC-1), then SAMPLE.
- SAMPLE: count ones of pd_out over 2**AVG_LOG2 consecutive cycles. inc = ones > 2**(AVG_LOG2-1). A tie is not inc. With AVG_LOG2=0, inc = the single sample.
  - At the end of the window:
    - inc & cnt_full: go to SAT.
    - inc & !cnt_full: go to STEP.
    - !inc: go to LOCKED.
- STEP: exactly one cycle. cnt_dir=1, cnt_hold=0 (negedge-aligned). Then SETTLE with a fresh count.
- LOCKED: dcc_code <= cnt_q on entry. dcc_done=1, cnt_hold=1, cnt_dir=0. Code is frozen; pd_out is ignored.
- SAT: same as LOCKED plus dcc_err=1.
- Boundary rules:
  - cnt_q=31 is treated as full even if cnt_full disagrees only when the shadow check is enabled; otherwise cnt_full is authoritative.
  - No wrap: the controller never pulses cnt_dir when cnt_full=1.
- dcc_en=0 in any state: IDLE on the next posedge. A pending or active STEP pulse is aborted (cnt_dir=0 from the next negedge). dcc_done, dcc_err and dcc_code clear, and cnt_nrst asserts, resetting the counter to 0.
- dcc_en must see 1 again to restart. Re-enabling while in IDLE restarts the search from code 0.
- Latency, dcc_en rise to first STEP: 1 + SETTLE_CYC + 2**AVG_LOG2 cycles. Each subsequent step: SETTLE_CYC + 2**AVG_LOG2 + 1 cycles.

Optional Feature:
AIBND_DCC_SHADOW_CHK_EN
- Defined:
  - An internal 5-bit shadow counter is cleared in IDLE and incremented on each STEP.
  - On entering SAMPLE, if cnt_q != shadow, go to SAT with dcc_err=1 and dcc_code=cnt_q.
  - Adds output shadow_mismatch (1 bit), which is sticky until IDLE.
- Undefined: no shadow logic, no shadow_mismatch port; cnt_q is used only for the dcc_code capture.

Test Plan:
- Reset mid-search: rst=1 during STEP -> cnt_dir=0, cnt_nrst=0, cnt_hold=1, dcc_done=0 immediately (async); IDLE after release.
- Model counter, pd_out=1 while code<13, else 0 (defaults 8/2) -> exactly 13 cnt_dir pulses, each one cycle wide and negedge-aligned; dcc_done=1, dcc_code=13, dcc_err=0; first pulse at cycle 13 after dcc_en rise.
- pd_out stuck 1 -> 31 pulses, then SAT: dcc_done=1, dcc_err=1, dcc_code=31; no 32nd pulse.
- Tie/majority: pd_out pattern 1,1,0,0 per window -> no step, LOCKED at code 0. Pattern 1,1,1,0 -> step.
- dcc_en dropped during SETTLE at code 7 -> next cycle IDLE, cnt_nrst=0, dcc_code=0. Re-enable -> search restarts from 0.
- With AIBND_DCC_SHADOW_CHK_EN: counter model skips one increment at code 5 -> on the next SAMPLE entry, shadow_mismatch=1, dcc_err=1, dcc_done=1, dcc_code=5.
